// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch bank write controller.
//   state_e : write-sequence FSM states (IDLE / SETUP / PULSE / HOLD)
//   dbg_t   : debug view of the controller (FSM state + arbiter pointer)
//   DEF_*   : default parameter values
//   max3()  : helper used to size the phase counter
package latch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    typedef struct packed {
        state_e state;
        logic   rr_ptr;
    } dbg_t;

    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_HOLD_CYC  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/latch_bank_write_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector, bit i = requester i
//   advance  : a grant is being taken this cycle; move the pointer
//   grant    : one-hot grant (all-zero when no request)
//   ptr_q    : registered priority pointer (requester favoured on a tie)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       ptr_q
);

    logic ptr_d;

    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        // After a grant, favour the requester that was not just served.
        if (advance && (grant != 2'b00)) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Write sequencer for a bank of level-sensitive D latches.
// Two requesters are arbitrated round-robin; each write runs
// IDLE -> SETUP (data stable, enables low) -> PULSE (one enable high)
// -> HOLD (data held, enables low) -> IDLE.
//
// Handshake: reqN is a level held (with stable addrN/dataN) until ackN.
// ackN is a one-cycle pulse in the last HOLD cycle; in the following
// cycle the requester drops reqN or presents a new write. A req still
// high in IDLE is a new request; a req dropped before grant is ignored.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req0/1          : write requests
//   addr0/1, data0/1: write address / data per requester
//   ack0/1          : completion pulses
//   lat_d           : registered shared latch data bus
//   lat_en          : registered one-hot (or zero) latch enables
//   busy            : controller not in IDLE
//   dbg             : FSM state and arbiter pointer
module latch_bank_write_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [DATA_W-1:0]    data0,
    input  logic [DATA_W-1:0]    data1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [DATA_W-1:0]    lat_d,
    output logic [2**ADDR_W-1:0] lat_en,
    output logic                 busy,
    output dbg_t                 dbg
);

    localparam int WORDS   = 2**ADDR_W;
    localparam int CNT_MAX = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               sel_q, sel_d;
    logic [WORDS-1:0]   lat_en_q, lat_en_d;

    logic [1:0]         grant;
    logic               rr_ptr;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1, req0}),
        .advance (state_q == ST_IDLE),
        .grant   (grant),
        .ptr_q   (rr_ptr)
    );

    // The phase counter counts down from (phase length - 1) and is
    // reloaded on every state entry; a phase ends when it reads zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        sel_d    = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    sel_d   = grant[1];
                    addr_d  = grant[1] ? addr1 : addr0;
                    data_d  = grant[1] ? data1 : data0;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Enables are decoded from the next state so the flop output is
        // high exactly for the PULSE cycles, with no input-to-output path.
        lat_en_d = '0;
        if (state_d == ST_PULSE) begin
            lat_en_d = WORDS'(1) << addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            sel_q    <= 1'b0;
            lat_en_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            lat_en_q <= lat_en_d;
        end
    end

    assign lat_d  = data_q;
    assign lat_en = lat_en_q;
    assign busy   = (state_q != ST_IDLE);
    // Last HOLD cycle of the granted requester; decoded from flops only.
    assign ack0   = (state_q == ST_HOLD) && (cnt_q == '0) && !sel_q;
    assign ack1   = (state_q == ST_HOLD) && (cnt_q == '0) &&  sel_q;
    assign dbg    = {state_q, rr_ptr};

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Bench for latch_bank_write_ctrl: instance 0 uses default timing
// (1/2/1), instance 1 uses SETUP=3, PULSE=1, HOLD=2. A reference model
// tracks each write as an offset from its grant cycle and predicts every
// output each cycle; a latch-array model checks the stored words.
module tb_latch_bank_write_ctrl;
    import latch_ctrl_pkg::*;

    logic clk;
    logic rst;
    logic       req    [2][2];
    logic [2:0] addr   [2][2];
    logic [7:0] data   [2][2];
    logic       ack    [2][2];
    logic [7:0] lat_d_o [2];
    logic [7:0] lat_en_o[2];
    logic       busy_o  [2];
    dbg_t       dbg_o   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Timing per instance
    int s_cyc[2] = '{1, 3};
    int p_cyc[2] = '{2, 1};
    int h_cyc[2] = '{1, 2};

    // Reference model state
    int         k      [2];   // offset of current cycle from grant; 0 = idle
    int         who    [2];
    int         ptr    [2];
    logic [2:0] cap_addr[2];
    logic [7:0] cap_data[2];
    logic [7:0] exp_mem[2][8];
    logic [7:0] lat_mem[2][8];
    bit         known  [2][8];
    logic [1:0] exp_q[$];

    latch_bank_write_ctrl u_dut0 (
        .clk(clk), .rst(rst),
        .req0(req[0][0]), .req1(req[0][1]),
        .addr0(addr[0][0]), .addr1(addr[0][1]),
        .data0(data[0][0]), .data1(data[0][1]),
        .ack0(ack[0][0]), .ack1(ack[0][1]),
        .lat_d(lat_d_o[0]), .lat_en(lat_en_o[0]),
        .busy(busy_o[0]), .dbg(dbg_o[0])
    );

    latch_bank_write_ctrl #(
        .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .req0(req[1][0]), .req1(req[1][1]),
        .addr0(addr[1][0]), .addr1(addr[1][1]),
        .data0(data[1][0]), .data1(data[1][1]),
        .ack0(ack[1][0]), .ack1(ack[1][1]),
        .lat_d(lat_d_o[1]), .lat_en(lat_en_o[1]),
        .busy(busy_o[1]), .dbg(dbg_o[1])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT samples.
    task automatic model_step(input int n);
        int t;
        t = 1 + s_cyc[n] + p_cyc[n] + h_cyc[n];
        if (rst) begin
            if (k[n] != 0) known[n][cap_addr[n]] = 1'b0;
            k[n]        = 0;
            ptr[n]      = 0;
            cap_data[n] = 8'h00;
        end else if (k[n] == 0) begin
            if (req[n][0] || req[n][1]) begin
                if (req[n][0] && req[n][1]) who[n] = ptr[n];
                else                        who[n] = req[n][1] ? 1 : 0;
                ptr[n]      = 1 - who[n];
                cap_addr[n] = addr[n][who[n]];
                cap_data[n] = data[n][who[n]];
                k[n]        = 1;
            end
        end else if (k[n] == t - 1) begin
            exp_mem[n][cap_addr[n]] = cap_data[n];
            known[n][cap_addr[n]]   = 1'b1;
            k[n] = 0;
        end else begin
            k[n] = k[n] + 1;
        end
    endtask

    task automatic model_compare(input int n);
        int         t;
        logic [7:0] e_en;
        t    = 1 + s_cyc[n] + p_cyc[n] + h_cyc[n];
        e_en = 8'h00;
        if (k[n] >= s_cyc[n] + 1 && k[n] <= s_cyc[n] + p_cyc[n]) e_en = 8'h01 << cap_addr[n];
        check($sformatf("u%0d_lat_en", n), lat_en_o[n], e_en);
        check($sformatf("u%0d_lat_d", n),  lat_d_o[n],  cap_data[n]);
        check($sformatf("u%0d_busy", n),   busy_o[n],   k[n] != 0);
        check($sformatf("u%0d_ack0", n),   ack[n][0],   (k[n] == t - 1) && (who[n] == 0));
        check($sformatf("u%0d_ack1", n),   ack[n][1],   (k[n] == t - 1) && (who[n] == 1));
        for (int i = 0; i < 8; i++) begin
            if (lat_en_o[n][i]) lat_mem[n][i] = lat_d_o[n];
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int n = 0; n < 2; n++) model_step(n);
        #1;
        for (int n = 0; n < 2; n++) model_compare(n);
    end

    // ---------------- driver tasks ----------------
    task automatic new_write(input int n, input int r);
        req[n][r]  = 1'b1;
        addr[n][r] = 3'($urandom_range(0, 7));
        data[n][r] = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_ack(input int n, input int r, input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ack[n][r]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check($sformatf("u%0d_ack%0d_timeout", n, r), 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t_ack, t_last, got;
        logic [7:0] e_en0, e_en1;
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            k[n] = 0; ptr[n] = 0; who[n] = 0; cap_addr[n] = 3'd0; cap_data[n] = 8'h00;
            for (int i = 0; i < 8; i++) begin
                exp_mem[n][i] = 8'h00; lat_mem[n][i] = 8'h00; known[n][i] = 1'b0;
            end
            for (int r = 0; r < 2; r++) begin
                req[n][r] = 1'b0; addr[n][r] = 3'd0; data[n][r] = 8'h00;
            end
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_lat_en", lat_en_o[0], 8'h00);
        check("rst_lat_d",  lat_d_o[0],  8'h00);
        check("rst_busy",   busy_o[0],   1'b0);
        check("rst_ack0",   ack[0][0],   1'b0);
        check("rst_ack1",   ack[0][1],   1'b0);
        check("rst_state",  dbg_o[0].state, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);

        // Single write on both instances: addr 5 / 0xA5 and addr 6 / 0x5A
        req[0][0] = 1'b1; addr[0][0] = 3'd5; data[0][0] = 8'hA5;
        req[1][0] = 1'b1; addr[1][0] = 3'd6; data[1][0] = 8'h5A;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            e_en0 = (c == 2 || c == 3) ? 8'h20 : 8'h00;
            e_en1 = (c == 4) ? 8'h40 : 8'h00;
            check($sformatf("t1_u0_c%0d_lat_en", c), lat_en_o[0], e_en0);
            check($sformatf("t1_u0_c%0d_ack0", c),   ack[0][0],   c == 4);
            check($sformatf("t1_u0_c%0d_busy", c),   busy_o[0],   c <= 4);
            check($sformatf("t1_u0_c%0d_lat_d", c),  lat_d_o[0],  8'hA5);
            check($sformatf("t1_u1_c%0d_lat_en", c), lat_en_o[1], e_en1);
            check($sformatf("t1_u1_c%0d_ack0", c),   ack[1][0],   c == 6);
            check($sformatf("t1_u1_c%0d_busy", c),   busy_o[1],   c <= 6);
            check($sformatf("t1_u1_c%0d_lat_d", c),  lat_d_o[1],  8'h5A);
            if (c == 4) req[0][0] = 1'b0;
            if (c == 6) req[1][0] = 1'b0;
        end

        // Only requester 1, three writes back to back
        @(negedge clk);
        new_write(0, 1);
        t_last = 0;
        for (int w = 0; w < 3; w++) begin
            wait_ack(0, 1, 20, t_ack);
            if (w > 0) check($sformatf("t3_gap%0d", w), t_ack - t_last, 5);
            t_last = t_ack;
            if (w < 2) new_write(0, 1);
            else req[0][1] = 1'b0;
        end

        // Both requesters held: grants alternate starting with 0
        @(negedge clk);
        exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
        new_write(0, 0);
        new_write(0, 1);
        t_last = 0;
        for (int w = 0; w < 4; w++) begin
            t_ack = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (ack[0][0] || ack[0][1]) begin
                    t_ack = cyc;
                    break;
                end
            end
            if (t_ack < 0) begin
                check("t2_timeout", 0, 1);
                break;
            end
            got = ack[0][1] ? 1 : 0;
            check($sformatf("t2_order%0d", w), got, exp_q.pop_front());
            if (w > 0) check($sformatf("t2_gap%0d", w), t_ack - t_last, 5);
            t_last = t_ack;
            new_write(0, got);
        end
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during PULSE, then a normal write
        req[0][0] = 1'b1; addr[0][0] = 3'd2; data[0][0] = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        check("t4_pulse_en", lat_en_o[0], 8'h04);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_en",   lat_en_o[0], 8'h00);
        check("t4_rst_busy", busy_o[0],   1'b0);
        check("t4_rst_ack0", ack[0][0],   1'b0);
        check("t4_rst_lat_d", lat_d_o[0], 8'h00);
        rst = 1'b0;
        wait_ack(0, 0, 20, t_ack);
        check("t4_after_lat_d", lat_d_o[0], 8'h3C);
        req[0][0] = 1'b0;

        // Random traffic on both instances with occasional resets
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            for (int n = 0; n < 2; n++) begin
                for (int r = 0; r < 2; r++) begin
                    if (req[n][r] && ack[n][r]) begin
                        if ($urandom_range(0, 1) == 1) new_write(n, r);
                        else req[n][r] = 1'b0;
                    end else if (!req[n][r] && $urandom_range(0, 2) == 0) begin
                        new_write(n, r);
                    end
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            req[n][0] = 1'b0;
            req[n][1] = 1'b0;
        end
        repeat (20) @(negedge clk);

        // Latch array contents against completed writes
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 8; i++) begin
                if (known[n][i]) check($sformatf("u%0d_mem%0d", n, i), lat_mem[n][i], exp_mem[n][i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/latch_bank_write_ctrl.md
# latch_bank_write_ctrl

Sequencer and arbiter for a bank of level-sensitive D latches (D/En/Q cells, transparent while En is high). It accepts write requests from two requesters, arbitrates between them round-robin, and drives a shared latch data bus plus one-hot latch enables. Each write follows a guarded sequence: data stable, then enable pulse, then data hold. This prevents glitches and races from reaching the transparent latches. It sits between the clocked control logic and the latch storage array.

## Interface
- ADDR_W, 3, latch-word address width; bank holds 2**ADDR_W words
- DATA_W, 8, width of each latch word
- SETUP_CYC, 1, cycles lat_d is stable with all enables low before the pulse (>=1)
- PULSE_CYC, 2, cycles the selected enable is high (>=1)
- HOLD_CYC, 1, cycles lat_d is held with all enables low after the pulse (>=1)
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req0, req1  in  1  write request per requester; level, held until matching ack
- addr0, addr1  in  ADDR_W  target word; stable while req high
- data0, data1  in  DATA_W  write data; stable while req high
- ack0, ack1  out  1  one-cycle completion pulse per requester
- lat_d  out  DATA_W  shared data bus to all latch D inputs
- lat_en  out  2**ADDR_W  per-word latch enables; one-hot or all-zero
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE: if any req is high, grant one requester, capture its addr/data into registers, and go to SETUP. Otherwise stay in IDLE.
- Arbitration is round-robin. The priority pointer starts at requester 0 and moves to the other requester after each grant. With a single requester, that requester is granted regardless of the pointer.
- SETUP: lat_d = captured data, lat_en = 0. Lasts SETUP_CYC cycles, then goes to PULSE.
- PULSE: lat_d held, lat_en[captured addr] = 1 and all other bits 0. Lasts PULSE_CYC cycles, then goes to HOLD.
- HOLD: lat_d held, lat_en = 0. Lasts HOLD_CYC cycles, then goes to IDLE. The granted ack is high during the final HOLD cycle only.
- lat_d changes only on the IDLE->SETUP edge. It keeps the last written value in IDLE.
- A requester must drop req, or present a new write, in the cycle after its ack. A req still high in IDLE is treated as a new request.
- A req that drops before its grant is ignored with no error. Inputs are not sampled after capture.
- Phase counter width is $clog2(max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1). It reloads on every state entry.

## Timing
- Reset values: state IDLE, lat_en 0, lat_d 0, ack0/ack1 0, busy 0, pointer favours requester 0.
- Reset mid-operation: on the next rising edge lat_en goes to 0 and the transaction is aborted with no ack. The aborted word's latch content is undefined.
- Grant decision is made in the IDLE cycle. The first SETUP cycle is the next cycle.
- Occupancy per write is 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC cycles, which is 5 with the defaults.
- Back-to-back throughput is one write per occupancy period. The next grant can occur in the IDLE cycle immediately following HOLD.
- lat_en and lat_d are registered outputs with no combinational path from inputs, so they are glitch-free.
- ack0 and ack1 are never high in the same cycle.

## Structure
- Shared package latch_ctrl_pkg holds the state enum type (IDLE/SETUP/PULSE/HOLD) and the default parameter constants.
- Sub-module rr_arb2 is a two-requester round-robin arbiter with inputs req[1:0] and advance, and outputs grant[1:0] (one-hot) and a registered pointer.
- The top level contains the FSM, phase counter, capture registers and one-hot address decode.

## Test plan
- Reset, then req0 with addr0=5 and data0=0xA5: lat_d=0xA5 from cycle 1. lat_en=0x20 in cycles 2-3 only. ack0 in cycle 4. busy high in cycles 1-4.
- req0 and req1 held continuously: grants alternate 0,1,0,1. Each write is 5 cycles. No cycle has two lat_en bits set or both acks high.
- Only req1 active for 3 writes: all three are granted to requester 1 with no idle gap beyond the single IDLE cycle between writes.
- Assert rst during PULSE: next cycle lat_en=0, busy=0, no ack. A subsequent req0 completes normally.
- Parameters SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2: lat_en is high exactly 1 cycle, 3 cycles after lat_d changes. ack comes 2 cycles after the pulse ends.
- In every test, a checker model of 2**ADDR_W latches driven by lat_d and lat_en matches the expected written words.
